// File: rtl/instruction_queue.sv
// In-order instruction queue feeding the dispatch unit.
// Circular buffer with registered issue outputs: each accepted pop presents
// the oldest entry on Instr_out with a one-cycle Issue_valid strobe and a
// wrapping sequence tag. Stall from the reservation stations blocks pops.
module instruction_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Push,
  input  logic [DATA_WIDTH-1:0]        Instr_in,
  input  logic                         Pop,
  input  logic                         Stall,
  output logic [DATA_WIDTH-1:0]        Instr_out,
  output logic                         Issue_valid,
  output logic [TAG_WIDTH-1:0]         Issue_tag,
  output logic [$clog2(DEPTH):0]       Count,
  output logic                         Full,
  output logic                         Empty,
  output logic                         Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_instr_out;
  logic                  r_issue_valid;
  logic [TAG_WIDTH-1:0]  r_issue_tag;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  // Occupancy flags decoded from the registered count; a pop frees a slot
  // in the same cycle so a push at Full is still accepted alongside a pop.
  always_comb begin
    w_full    = (r_count == CW'(DEPTH));
    w_empty   = (r_count == {CW{1'b0}});
    w_pop_ok  = Pop && !Stall && !w_empty;
    w_push_ok = Push && (!w_full || w_pop_ok);
  end

  // Storage write; contents are never cleared, pointers make stale data unreachable.
  always_ff @(posedge Clock) begin
    if (w_push_ok && !Reset) begin
      r_mem[r_wr_ptr] <= Instr_in;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_ptr   <= {AW{1'b0}};
      r_wr_ptr   <= {AW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (Push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Issue stage: registered instruction, tag and strobe; data and tag hold when idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_instr_out   <= {DATA_WIDTH{1'b0}};
      r_issue_valid <= 1'b0;
      r_issue_tag   <= {TAG_WIDTH{1'b0}};
      r_tag         <= {TAG_WIDTH{1'b0}};
    end else if (w_pop_ok) begin
      r_instr_out   <= r_mem[r_rd_ptr];
      r_issue_valid <= 1'b1;
      r_issue_tag   <= r_tag;
      r_tag         <= r_tag + TAG_WIDTH'(1);
    end else begin
      r_issue_valid <= 1'b0;
    end
  end

  assign Instr_out   = r_instr_out;
  assign Issue_valid = r_issue_valid;
  assign Issue_tag   = r_issue_tag;
  assign Count       = r_count;
  assign Full        = w_full;
  assign Empty       = w_empty;
  assign Overflow    = r_overflow;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue with a reference queue and an issue scoreboard.
module tb_instruction_queue;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int TW    = 4;

  logic          Clock;
  logic          Reset;
  logic          Push;
  logic [DW-1:0] Instr_in;
  logic          Pop;
  logic          Stall;
  logic [DW-1:0] Instr_out;
  logic          Issue_valid;
  logic [TW-1:0] Issue_tag;
  logic [3:0]    Count;
  logic          Full;
  logic          Empty;
  logic          Overflow;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  logic [DW-1:0] mq[$];   // reference contents of the queue
  exp_t          sb[$];   // expected issues, pushed when a pop is driven
  logic [TW-1:0] m_tag;
  logic          m_ovf;
  int            n_checks;
  int            n_fail;

  instruction_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .Clock(Clock), .Reset(Reset), .Push(Push), .Instr_in(Instr_in),
    .Pop(Pop), .Stall(Stall), .Instr_out(Instr_out), .Issue_valid(Issue_valid),
    .Issue_tag(Issue_tag), .Count(Count), .Full(Full), .Empty(Empty),
    .Overflow(Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, then compare after the edge.
  task automatic step(input logic rst, input logic push, input logic [DW-1:0] d,
                      input logic pop, input logic stall);
    logic m_pop;
    logic m_push;
    exp_t e;
    Reset = rst; Push = push; Instr_in = d; Pop = pop; Stall = stall;
    m_pop  = pop && !stall && (mq.size() != 0);
    m_push = push && ((mq.size() < DEPTH) || m_pop);
    if (rst) begin
      mq.delete();
      sb.delete();
      m_tag = 4'd0;
      m_ovf = 1'b0;
      m_pop = 1'b0;
    end else begin
      if (m_pop) begin
        e.data = mq.pop_front();
        e.tag  = m_tag;
        sb.push_back(e);
        m_tag  = m_tag + 4'd1;
      end
      if (m_push) mq.push_back(d);
      if (push && !m_push) m_ovf = 1'b1;
    end
    @(posedge Clock);
    #1;
    check("issue_valid", 32'(Issue_valid), 32'(m_pop));
    if (m_pop) begin
      e = sb.pop_front();
      check("instr_out", 32'(Instr_out), 32'(e.data));
      check("issue_tag", 32'(Issue_tag), 32'(e.tag));
    end else if (rst) begin
      check("rst_instr_out", 32'(Instr_out), 32'd0);
      check("rst_issue_tag", 32'(Issue_tag), 32'd0);
    end
    check("count",    32'(Count),    32'(mq.size()));
    check("full",     32'(Full),     32'(mq.size() == DEPTH));
    check("empty",    32'(Empty),    32'(mq.size() == 0));
    check("overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_tag = 4'd0; m_ovf = 1'b0;
    Reset = 1'b1; Push = 1'b0; Instr_in = 16'h0000; Pop = 1'b0; Stall = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

    // ADD then SUB, back-to-back issue
    step(1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h1012, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("add_out", 32'(Instr_out), 32'h0012);
    check("add_tag", 32'(Issue_tag), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("sub_out", 32'(Instr_out), 32'h1012);
    check("sub_tag", 32'(Issue_tag), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("drained_empty", 32'(Empty), 32'd1);

    // Fill, overflow, drain in order, pop on empty ignored
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    check("fill_full", 32'(Full), 32'd1);
    check("fill_count", 32'(Count), 32'd8);
    step(1'b0, 1'b1, 16'h0099, 1'b0, 1'b0);
    check("ovf_set", 32'(Overflow), 32'd1);
    check("ovf_count", 32'(Count), 32'd8);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("ninth_pop_none", 32'(Issue_valid), 32'd0);

    // Push and pop together at Full
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h00AA, 1'b1, 1'b0);
    check("full_pp_out", 32'(Instr_out), 32'h0000);
    check("full_pp_count", 32'(Count), 32'd8);
    check("full_pp_ovf", 32'(Overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("aa_eighth", 32'(Instr_out), 32'h00AA);

    // Stall blocks pops, then issue resumes
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h1678, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check("stall_count", 32'(Count), 32'd2);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // No bypass on empty
    step(1'b0, 1'b1, 16'h0abc, 1'b1, 1'b0);
    check("nobypass_count", 32'(Count), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("nobypass_late", 32'(Instr_out), 32'h0abc);

    // 17 issues across pointer wrap: tags 0..15 then 0
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    for (int i = 1; i < 17; i++) step(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("wrap_tag", 32'(Issue_tag), 32'd0);
    check("wrap_data", 32'(Instr_out), 32'h0110);

    // Reset mid-stream overrides push/pop
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h0301, 1'b1, 1'b0);
    check("mid_rst_empty", 32'(Empty), 32'd1);
    step(1'b0, 1'b1, 16'h0400, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("post_rst_tag", 32'(Issue_tag), 32'd0);
    check("post_rst_data", 32'(Instr_out), 32'h0400);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
